// File: rtl/nn_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nn_seq_pkg : shared types and widths for the nn instruction sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package nn_seq_pkg;

  localparam int INSTR_W = 25;
  localparam int DATA_W  = 16;
  localparam int AUX_W   = 8;
  localparam int WORD_W  = 2 + AUX_W + INSTR_W;

  typedef enum logic [1:0] {
    OP_ISSUE = 2'd0,
    OP_WAIT  = 2'd1,
    OP_LOOP  = 2'd2,
    OP_HALT  = 2'd3
  } seq_op_e;

  typedef struct packed {
    seq_op_e                op;
    logic [AUX_W-1:0]       aux;
    logic [INSTR_W-1:0]     payload;
  } seq_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAITV = 2'd2
  } state_e;

  function automatic logic [AUX_W-1:0] sat_inc(input logic [AUX_W-1:0] v);
    return (v == {AUX_W{1'b1}}) ? v : v + AUX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_seq_progmem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nn_seq_progmem : flop-based program store, sync write, combinational read
// Rev 1.0
// ----------------------------------------------------------------------------
module nn_seq_progmem
  import nn_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 32,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            busy,
  input  logic [AW-1:0]   waddr,
  input  seq_word_t       wdata,
  input  logic [AW-1:0]   raddr,
  output seq_word_t       rdata
);

  seq_word_t mem_q [PROG_DEPTH];
  seq_word_t mem_d [PROG_DEPTH];

  // Writes are dropped while a program is executing.
  always_comb begin
    for (int i = 0; i < PROG_DEPTH; i++) begin
      mem_d[i] = (we && !busy && (waddr == AW'(i))) ? wdata : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PROG_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/nn_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nn_sequencer : program-driven micro-sequencer for the 2x2 nn instruction bus
// Rev 1.0
// ----------------------------------------------------------------------------
module nn_sequencer
  import nn_seq_pkg::*;
#(
  parameter  int PROG_DEPTH = 32,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [AW-1:0]            prog_addr,
  input  logic [WORD_W-1:0]        prog_wdata,
  input  logic [AUX_W-1:0]         loop_count,
  input  logic                     start,
  output logic [INSTR_W-1:0]       instruction,
  input  logic                     nn_valid_out_1,
  input  logic                     nn_valid_out_2,
  input  logic signed [DATA_W-1:0] nn_data_out_1,
  input  logic signed [DATA_W-1:0] nn_data_out_2,
  output logic signed [DATA_W-1:0] result_1,
  output logic signed [DATA_W-1:0] result_2,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [AW-1:0]            pc
);

  localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

  state_e                    state_q, state_d;
  logic [AW-1:0]             pc_q, pc_d;
  logic [AUX_W-1:0]          hold_q, hold_d;
  logic [AUX_W-1:0]          tmo_q, tmo_d;
  logic [AUX_W-1:0]          loop_q, loop_d;
  logic                      seen_1_q, seen_1_d;
  logic                      seen_2_q, seen_2_d;
  logic                      eop_q, eop_d;
  logic signed [DATA_W-1:0]  result_1_q, result_1_d;
  logic signed [DATA_W-1:0]  result_2_q, result_2_d;
  logic                      result_valid_q, result_valid_d;
  logic                      timeout_err_q, timeout_err_d;

  seq_word_t                 word;
  logic [INSTR_W-1:0]        instr;
  logic                      done_c;
  logic                      abort_c;
  logic                      busy_c;
  logic                      last_pc;
  logic [AW-1:0]             pc_inc;

  nn_seq_progmem #(
    .PROG_DEPTH (PROG_DEPTH),
    .AW         (AW)
  ) u_progmem (
    .clk   (clk),
    .we    (prog_we),
    .busy  (busy_c),
    .waddr (prog_addr),
    .wdata (seq_word_t'(prog_wdata)),
    .raddr (pc_q),
    .rdata (word)
  );

  assign last_pc = (pc_q == PC_LAST);
  assign pc_inc  = pc_q + AW'(1);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    tmo_d          = tmo_q;
    loop_d         = loop_q;
    seen_1_d       = seen_1_q;
    seen_2_d       = seen_2_q;
    eop_d          = eop_q;
    result_1_d     = result_1_q;
    result_2_d     = result_2_q;
    result_valid_d = 1'b0;
    timeout_err_d  = timeout_err_q;
    instr          = '0;
    done_c         = 1'b0;
    abort_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RUN;
          pc_d          = '0;
          loop_d        = loop_count;
          timeout_err_d = 1'b0;
          hold_d        = '0;
          tmo_d         = '0;
          seen_1_d      = 1'b0;
          seen_2_d      = 1'b0;
          eop_d         = 1'b0;
        end
      end

      ST_RUN: begin
        // Running off the end of the program behaves exactly like HALT.
        if (eop_q || (word.op == OP_HALT)) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
          eop_d   = 1'b0;
        end else begin
          case (word.op)
            OP_ISSUE: begin
              instr = word.payload;
              if (hold_q >= word.aux) begin
                hold_d = '0;
                if (last_pc) eop_d = 1'b1;
                else         pc_d  = pc_inc;
              end else begin
                hold_d = sat_inc(hold_q);
              end
            end
            OP_WAIT: begin
              instr    = word.payload;
              state_d  = ST_WAITV;
              tmo_d    = '0;
              seen_1_d = 1'b0;
              seen_2_d = 1'b0;
            end
            OP_LOOP: begin
              if (loop_q != '0) begin
                loop_d = loop_q - AUX_W'(1);
                pc_d   = AW'(word.aux);
              end else if (last_pc) begin
                eop_d = 1'b1;
              end else begin
                pc_d = pc_inc;
              end
            end
            default: ;
          endcase
        end
      end

      ST_WAITV: begin
        instr = word.payload;
        if (nn_valid_out_1) begin
          result_1_d = nn_data_out_1;
          seen_1_d   = 1'b1;
        end
        if (nn_valid_out_2) begin
          result_2_d = nn_data_out_2;
          seen_2_d   = 1'b1;
        end
        // Completion wins over a timeout expiring in the same cycle.
        if (seen_1_d && seen_2_d) begin
          result_valid_d = 1'b1;
          seen_1_d       = 1'b0;
          seen_2_d       = 1'b0;
          hold_d         = '0;
          state_d        = ST_RUN;
          if (last_pc) eop_d = 1'b1;
          else         pc_d  = pc_inc;
        end else if ((word.aux != '0) && (tmo_q >= (word.aux - AUX_W'(1)))) begin
          abort_c       = 1'b1;
          done_c        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = sat_inc(tmo_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      hold_q         <= '0;
      tmo_q          <= '0;
      loop_q         <= '0;
      seen_1_q       <= 1'b0;
      seen_2_q       <= 1'b0;
      eop_q          <= 1'b0;
      result_1_q     <= '0;
      result_2_q     <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_q         <= hold_d;
      tmo_q          <= tmo_d;
      loop_q         <= loop_d;
      seen_1_q       <= seen_1_d;
      seen_2_q       <= seen_2_d;
      eop_q          <= eop_d;
      result_1_q     <= result_1_d;
      result_2_q     <= result_2_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign busy_c       = (state_q != ST_IDLE) && !done_c;
  assign busy         = busy_c;
  assign done         = done_c;
  assign instruction  = instr;
  assign result_1     = result_1_q;
  assign result_2     = result_2_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q | abort_c;
  assign pc           = pc_q;

endmodule
`default_nettype wire
